// File: rtl/mealy_fsm_pkg.sv
// Shared types for the 010/101 Mealy sequence detector.
//   state_t : 3-bit state encoding. Codes 5..7 are illegal and recover to IDLE.
package mealy_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,  // no history
    S0   = 3'd1,  // last bit 0
    S1   = 3'd2,  // last bit 1
    S01  = 3'd3,  // last bits 01
    S10  = 3'd4   // last bits 10
  } state_t;

endpackage

// File: rtl/mealy_fsm.sv
// mealy_fsm: serial detector for the patterns 010 and 101.
// Mealy outputs are combinational, so a detect flag rises in the same cycle
// as the bit that completes the pattern.
//
// Parameters
//   OVERLAP : 1 = a completed pattern seeds the next one; 0 = restart from IDLE
//   EN_010  : 1 = report 010
//   EN_101  : 1 = report 101
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active high
//   in      : serial data bit
//   out     : det_010 | det_101
//   det_010 : current in completes 010
//   det_101 : current in completes 101
module mealy_fsm
  import mealy_fsm_pkg::*;
#(
  parameter int OVERLAP = 1,
  parameter int EN_010  = 1,
  parameter int EN_101  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic det_010,
  output logic det_101
);

  localparam logic OVL   = (OVERLAP != 0);
  localparam logic EN10  = (EN_010 != 0);
  localparam logic EN101 = (EN_101 != 0);

  state_t state, state_nxt;
  logic   hit_010, hit_101;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Transitions never look at the enables. The enables only mask the
  // reported flags, so history tracking is identical in every configuration.
  always_comb begin
    state_nxt = IDLE;
    hit_010   = 1'b0;
    hit_101   = 1'b0;
    case (state)
      IDLE: state_nxt = in ? S1 : S0;
      S0:   state_nxt = in ? S01 : S0;
      S1:   state_nxt = in ? S1 : S10;
      S01: begin
        if (in) state_nxt = S1;
        else begin
          hit_010   = 1'b1;
          state_nxt = OVL ? S10 : IDLE;
        end
      end
      S10: begin
        if (in) begin
          hit_101   = 1'b1;
          state_nxt = OVL ? S01 : IDLE;
        end else state_nxt = S0;
      end
      default: state_nxt = IDLE;  // illegal code: flags stay 0
    endcase
  end

  // Gating with rst keeps the flags low during reset without relying on the
  // register having already settled.
  assign det_010 = hit_010 & EN10 & ~rst;
  assign det_101 = hit_101 & EN101 & ~rst;
  assign out     = det_010 | det_101;

endmodule

// File: tb/tb_mealy_fsm.sv
// Scoreboard bench for mealy_fsm. Four configurations share clk, rst and in:
//   a: defaults, b: OVERLAP=0, c: EN_101=0, d: EN_010=0.
// The stimulus pushes the hand-computed flags {out,det_010,det_101} for each
// instance. The monitor compares them on the falling edge.
module tb_mealy_fsm;
  import mealy_fsm_pkg::*;

  localparam logic [2:0] Z    = 3'b000;
  localparam logic [2:0] P010 = 3'b110;
  localparam logic [2:0] P101 = 3'b101;

  typedef struct {
    logic [3:0][2:0] e;    // [3]=a [2]=b [1]=c [0]=d
    logic            chk;  // also check the current state of instance c
    state_t          st;
    int              id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b0;
  logic vld = 1'b0;
  logic done = 1'b0;
  logic finished = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   vec_id = 0;
  exp_t q[$];

  logic oa, a10, a101, ob, b10, b101, oc, c10, c101, od, d10, d101;

  always #5 clk = ~clk;

  mealy_fsm dut_a (.clk(clk), .rst(rst), .in(in), .out(oa), .det_010(a10), .det_101(a101));
  mealy_fsm #(.OVERLAP(0)) dut_b (.clk(clk), .rst(rst), .in(in), .out(ob), .det_010(b10), .det_101(b101));
  mealy_fsm #(.EN_101(0))  dut_c (.clk(clk), .rst(rst), .in(in), .out(oc), .det_010(c10), .det_101(c101));
  mealy_fsm #(.EN_010(0))  dut_d (.clk(clk), .rst(rst), .in(in), .out(od), .det_010(d10), .det_101(d101));

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [3:0][2:0] act;
    exp_t x;
    string nm [4];
    nm[3] = "a"; nm[2] = "b"; nm[1] = "c"; nm[0] = "d";
    if (vld) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL scoreboard_underflow: actual queue empty, required an entry");
      end else begin
        x = q.pop_front();
        act = {{oa, a10, a101}, {ob, b10, b101}, {oc, c10, c101}, {od, d10, d101}};
        for (int k = 0; k < 4; k++) begin
          compared++;
          if (act[k] !== x.e[k]) begin
            mismatched++;
            $display("FAIL vec%0d_dut_%s {out,det_010,det_101}: actual %b required %b",
                     x.id, nm[k], act[k], x.e[k]);
          end
        end
        if (x.chk) begin
          compared++;
          if (dut_c.state !== x.st) begin
            mismatched++;
            $display("FAIL vec%0d_state_c: actual %0d required %0d", x.id, dut_c.state, x.st);
          end
        end
      end
    end
    if (done && !finished) begin
      compared++;
      if (q.size() != 0) begin
        mismatched++;
        $display("FAIL scoreboard_drain: actual %0d left, required 0", q.size());
      end
      finished <= 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  // Tasks are entered and left at posedge+1.
  task automatic push(input logic [3:0][2:0] e, input logic chk, input state_t st);
    exp_t x;
    x.e = e; x.chk = chk; x.st = st; x.id = vec_id;
    vec_id++;
    q.push_back(x);
  endtask

  task automatic drive(input logic b, input logic [3:0][2:0] e,
                       input logic chk = 1'b0, input state_t st = IDLE);
    in  = b;
    vld = 1'b1;
    push(e, chk, st);
    @(posedge clk); #1;
  endtask

  // Holds in=1 during reset: outputs must stay 0 and the state must be IDLE.
  task automatic do_reset();
    rst = 1'b1;
    in  = 1'b1;
    vld = 1'b1;
    push({Z, Z, Z, Z}, 1'b1, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;

    // 0,1,0 -> 010 on bit 3 only
    do_reset();
    drive(0, {Z, Z, Z, Z});
    drive(1, {Z, Z, Z, Z});
    drive(0, {P010, P010, P010, Z});

    // 0,1,0,0,1,0,1 -> overlapping 101 on bit 7
    do_reset();
    drive(0, {Z, Z, Z, Z});
    drive(1, {Z, Z, Z, Z});
    drive(0, {P010, P010, P010, Z});
    drive(0, {Z, Z, Z, Z});
    drive(1, {Z, Z, Z, Z});
    drive(0, {P010, P010, P010, Z});
    drive(1, {P101, Z, Z, P101});

    // 1,0,1,0,1: b restarts after bit 3; c masks 101 yet still reaches S01
    do_reset();
    drive(1, {Z, Z, Z, Z});
    drive(0, {Z, Z, Z, Z});
    drive(1, {P101, P101, Z, P101});
    drive(0, {P010, Z, P010, Z}, 1'b1, S01);
    drive(1, {P101, Z, Z, P101});

    // async reset between edges after 0,1. in=0 would complete 010 without it.
    do_reset();
    drive(0, {Z, Z, Z, Z});
    drive(1, {Z, Z, Z, Z});
    vld = 1'b0;
    in  = 1'b0;
    #2;
    rst = 1'b1;
    vld = 1'b1;
    push({Z, Z, Z, Z}, 1'b1, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, {Z, Z, Z, Z}, 1'b1, IDLE);
    drive(1, {Z, Z, Z, Z}, 1'b1, S0);
    drive(0, {P010, P010, P010, Z}, 1'b1, S01);

    // constant input never detects
    do_reset();
    for (int i = 0; i < 10; i++) drive(1, {Z, Z, Z, Z});
    do_reset();
    for (int i = 0; i < 10; i++) drive(0, {Z, Z, Z, Z});

    vld  = 1'b0;
    done = 1'b1;
    for (int i = 0; i < 20 && !finished; i++) @(posedge clk);
    if (!finished) begin
      mismatched++;
      $display("FAIL monitor_timeout: actual not drained, required drained");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
